// File: rtl/board_tx_if.sv
// Valid/ready byte channel from the board serializer to the UART transmitter.
interface board_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/board_tx.sv
// Serializes a 9x9 Go board snapshot into a frame: header, 21 packed cell bytes, XOR checksum.
module board_tx #(
    parameter logic [7:0] HEADER = 8'hA5
) (
    input  logic                  clk_in,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [8:0][8:0][1:0]  board_in,
    board_tx_if.master            tx,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned CELL_BITS = 162;
    localparam int unsigned IDX_W     = 5;
    localparam int unsigned LAST_IDX  = 20;

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_CSUM, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [7:0]           csum_q, csum_d;
    logic [CELL_BITS-1:0] snap_q, snap_d;
    logic [7:0]           data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 xfer;
    logic [7:0]           cur_byte;

    // Flat snapshot bit 2k holds cell k, so byte j is simply bits [8j+7:8j]; D20 is zero-padded.
    function automatic logic [7:0] data_byte(input logic [CELL_BITS-1:0] s,
                                             input logic [IDX_W-1:0] j);
        logic [255:0] pad;
        pad = 256'(s);
        return pad[{j, 3'b000} +: 8];
    endfunction

    assign xfer     = valid_q & tx.tx_ready;
    assign cur_byte = data_byte(snap_q, idx_q);

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            csum_q  <= '0;
            snap_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            snap_q  <= snap_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state; the outgoing byte is preloaded so it is registered when the state changes.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        snap_d  = snap_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_HDR;
                    idx_d   = '0;
                    csum_d  = '0;
                    snap_d  = board_in;
                    data_d  = HEADER;
                end
            end
            S_HDR: begin
                if (xfer) begin
                    state_d = S_DATA;
                    data_d  = data_byte(snap_q, IDX_W'(0));
                end
            end
            S_DATA: begin
                if (xfer) begin
                    csum_d = csum_q ^ cur_byte;
                    idx_d  = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(LAST_IDX)) begin
                        state_d = S_CSUM;
                        data_d  = csum_q ^ cur_byte;
                    end else begin
                        data_d  = data_byte(snap_q, idx_q + IDX_W'(1));
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    state_d = S_DONE;
                    data_d  = 8'h00;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        valid_d = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CSUM);
        busy_d  = valid_d;
        done_d  = (state_d == S_DONE);
    end

    assign tx.tx_data  = data_q;
    assign tx.tx_valid = valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_board_tx.sv
// Directed bench for board_tx: frame content, timing, backpressure, snapshot and reset abort.
module tb_board_tx;

    logic                 clk_in = 1'b0;
    logic                 reset_n;
    logic                 start;
    logic [8:0][8:0][1:0] board_in;
    logic                 busy;
    logic                 done;

    board_tx_if bus ();

    board_tx dut (
        .clk_in   (clk_in),
        .reset_n  (reset_n),
        .start    (start),
        .board_in (board_in),
        .tx       (bus),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk_in = ~clk_in;

    int         vec_n = 0;
    int         err_n = 0;
    logic [1:0] cells [0:8][0:8];
    logic [7:0] exp_b [0:22];
    logic [7:0] rx    [0:63];
    int         rx_n, done_n, done_cyc, stall_err, idle_err;
    bit         timeout;

    task automatic clear_cells();
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++) cells[r][c] = 2'b00;
    endtask

    task automatic apply_cells();
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++) board_in[r][c] = cells[r][c];
    endtask

    // Reference frame built cell by cell from row/column coordinates.
    task automatic build_expect();
        logic [7:0] b, c;
        int k;
        c = 8'h00;
        for (int j = 0; j < 21; j++) begin
            b = 8'h00;
            for (int i = 0; i < 4; i++) begin
                k = 4 * j + i;
                if (k < 81) b[2*i +: 2] = cells[k / 9][k % 9];
            end
            exp_b[j+1] = b;
            c = c ^ b;
        end
        exp_b[0]  = 8'hA5;
        exp_b[22] = c;
    endtask

    // Drives one frame and records the received stream; mode 1 applies the 1,0,0,1 ready pattern.
    task automatic run_frame(input int mode, input bit poke);
        logic       rdy, hold_v;
        logic [7:0] hold_d;
        timeout = 0; rx_n = 0; done_n = 0; done_cyc = -1; stall_err = 0; idle_err = 0;
        hold_v = 1'b0; hold_d = 8'h00;
        apply_cells();
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            if (hold_v && (bus.tx_data !== hold_d || bus.tx_valid !== 1'b1)) stall_err++;
            if (done === 1'b1) begin
                done_n++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc > done_cyc && (busy !== 1'b0 || bus.tx_valid !== 1'b0)) idle_err++;
            rdy = (mode == 0) ? 1'b1 : (((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3));
            bus.tx_ready = rdy;
            if (bus.tx_valid === 1'b1 && rdy) begin
                if (rx_n < 64) rx[rx_n] = bus.tx_data;
                rx_n++;
            end
            hold_v = (bus.tx_valid === 1'b1) && !rdy;
            hold_d = bus.tx_data;
            if (poke && cyc == 5) begin
                board_in[0][1] = 2'b01;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            @(negedge clk_in);
        end
        if (done_cyc < 0) timeout = 1;
        bus.tx_ready = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; bus.tx_ready = 1'b0;
        clear_cells(); apply_cells();
        repeat (2) @(negedge clk_in);
        vec_n++; if (bus.tx_valid !== 1'b0) begin err_n++; $display("FAIL reset_valid: got %b want 0", bus.tx_valid); end
        vec_n++; if (bus.tx_data !== 8'h00) begin err_n++; $display("FAIL reset_data: got %h want 00", bus.tx_data); end
        vec_n++; if (busy !== 1'b0) begin err_n++; $display("FAIL reset_busy: got %b want 0", busy); end
        vec_n++; if (done !== 1'b0) begin err_n++; $display("FAIL reset_done: got %b want 0", done); end
        reset_n = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic test_empty();
        clear_cells(); build_expect();
        run_frame(0, 1'b0);
        vec_n++; if (timeout) begin err_n++; $display("FAIL empty_timeout: no done within budget"); end
        vec_n++; if (rx_n !== 23) begin err_n++; $display("FAIL empty_len: got %0d want 23", rx_n); end
        vec_n++; if (rx[0] !== 8'hA5) begin err_n++; $display("FAIL empty_hdr: got %h want a5", rx[0]); end
        for (int j = 1; j < 23; j++) begin
            vec_n++; if (rx[j] !== 8'h00) begin err_n++; $display("FAIL empty_byte%0d: got %h want 00", j, rx[j]); end
        end
        vec_n++; if (done_cyc !== 24) begin err_n++; $display("FAIL empty_done_cyc: got %0d want 24", done_cyc); end
        vec_n++; if (done_n !== 1) begin err_n++; $display("FAIL empty_done_cnt: got %0d want 1", done_n); end
        vec_n++; if (idle_err !== 0) begin err_n++; $display("FAIL empty_idle_after: got %0d busy/valid cycles want 0", idle_err); end
    endtask

    task automatic test_corner();
        clear_cells(); cells[0][0] = 2'b01; cells[8][8] = 2'b10;
        run_frame(0, 1'b0);
        vec_n++; if (rx_n !== 23) begin err_n++; $display("FAIL corner_len: got %0d want 23", rx_n); end
        vec_n++; if (rx[1] !== 8'h01) begin err_n++; $display("FAIL corner_d0: got %h want 01", rx[1]); end
        for (int j = 2; j < 21; j++) begin
            vec_n++; if (rx[j] !== 8'h00) begin err_n++; $display("FAIL corner_d%0d: got %h want 00", j - 1, rx[j]); end
        end
        vec_n++; if (rx[21] !== 8'h02) begin err_n++; $display("FAIL corner_d20: got %h want 02", rx[21]); end
        vec_n++; if (rx[22] !== 8'h03) begin err_n++; $display("FAIL corner_csum: got %h want 03", rx[22]); end
    endtask

    task automatic test_packing();
        clear_cells();
        cells[0][0] = 2'b01; cells[0][1] = 2'b10; cells[0][2] = 2'b01; cells[0][3] = 2'b10;
        run_frame(0, 1'b0);
        vec_n++; if (rx[1] !== 8'h99) begin err_n++; $display("FAIL pack_d0: got %h want 99", rx[1]); end
        vec_n++; if (rx[22] !== 8'h99) begin err_n++; $display("FAIL pack_csum: got %h want 99", rx[22]); end
    endtask

    task automatic test_backpressure();
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++) cells[r][c] = 2'((r * 3 + c * 5) % 4);
        build_expect();
        run_frame(1, 1'b0);
        vec_n++; if (timeout) begin err_n++; $display("FAIL bp_timeout: no done within budget"); end
        vec_n++; if (rx_n !== 23) begin err_n++; $display("FAIL bp_len: got %0d want 23", rx_n); end
        for (int j = 0; j < 23; j++) begin
            vec_n++; if (rx[j] !== exp_b[j]) begin err_n++; $display("FAIL bp_byte%0d: got %h want %h", j, rx[j], exp_b[j]); end
        end
        vec_n++; if (stall_err !== 0) begin err_n++; $display("FAIL bp_stable: got %0d unstable stall cycles want 0", stall_err); end
        vec_n++; if (done_n !== 1) begin err_n++; $display("FAIL bp_done_cnt: got %0d want 1", done_n); end
    endtask

    task automatic test_snapshot();
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++) cells[r][c] = 2'((r + c * 2) % 4);
        cells[0][1] = 2'b00;
        build_expect();
        run_frame(0, 1'b1);
        vec_n++; if (rx_n !== 23) begin err_n++; $display("FAIL snap_len: got %0d want 23", rx_n); end
        for (int j = 0; j < 23; j++) begin
            vec_n++; if (rx[j] !== exp_b[j]) begin err_n++; $display("FAIL snap_byte%0d: got %h want %h", j, rx[j], exp_b[j]); end
        end
        vec_n++; if (done_n !== 1) begin err_n++; $display("FAIL snap_done_cnt: got %0d want 1", done_n); end
        vec_n++; if (idle_err !== 0) begin err_n++; $display("FAIL snap_no_refire: got %0d busy/valid cycles want 0", idle_err); end
    endtask

    task automatic test_reset_mid();
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++) cells[r][c] = 2'((r * 7 + c) % 4);
        build_expect();
        apply_cells();
        bus.tx_ready = 1'b1;
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        repeat (8) @(negedge clk_in);
        vec_n++; if (bus.tx_data !== exp_b[8]) begin err_n++; $display("FAIL rmid_d7: got %h want %h", bus.tx_data, exp_b[8]); end
        reset_n = 1'b0;
        #1;
        vec_n++; if (bus.tx_valid !== 1'b0) begin err_n++; $display("FAIL rmid_valid: got %b want 0", bus.tx_valid); end
        vec_n++; if (busy !== 1'b0) begin err_n++; $display("FAIL rmid_busy: got %b want 0", busy); end
        vec_n++; if (done !== 1'b0) begin err_n++; $display("FAIL rmid_done: got %b want 0", done); end
        vec_n++; if (bus.tx_data !== 8'h00) begin err_n++; $display("FAIL rmid_data: got %h want 00", bus.tx_data); end
        bus.tx_ready = 1'b0;
        @(negedge clk_in);
        reset_n = 1'b1;
        @(negedge clk_in);
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++) cells[r][c] = 2'((r * c + 1) % 4);
        build_expect();
        run_frame(0, 1'b0);
        vec_n++; if (rx_n !== 23) begin err_n++; $display("FAIL rmid_len: got %0d want 23", rx_n); end
        for (int j = 0; j < 23; j++) begin
            vec_n++; if (rx[j] !== exp_b[j]) begin err_n++; $display("FAIL rmid_byte%0d: got %h want %h", j, rx[j], exp_b[j]); end
        end
        vec_n++; if (done_cyc !== 24) begin err_n++; $display("FAIL rmid_done_cyc: got %0d want 24", done_cyc); end
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        bus.tx_ready = 1'b0;
        board_in = '0;
        @(negedge clk_in);
        test_reset();
        test_empty();
        test_corner();
        test_packing();
        test_backpressure();
        test_snapshot();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
        $finish;
    end

endmodule

// File: doc/board_tx.md
# board_tx

Serializes a full 9x9 Go board into a byte stream for the outbound link. It is the transmit-side counterpart to the board-receive path that feeds `game_fsm`. On a `start` request it snapshots the board, then emits one frame: header byte, packed cell bytes, checksum. The frame goes over a valid/ready byte interface into the UART transmitter.

## Interface
- `HEADER`, default 8'hA5: first byte of every frame.
- `clk_in`, input, 1: system clock; all state changes on its rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request to send one frame; sampled only in IDLE.
- `board_in [8:0][8:0]`, input, 2 each: cells, indexed `board_in[row][col]`. Encoding: 00 empty, 01 black, 10 white, 11 passed through unchanged.
- `tx_data`, output, 8: current byte offered downstream.
- `tx_valid`, output, 1: `tx_data` is valid.
- `tx_ready`, input, 1: downstream accepts `tx_data` this cycle.
- `busy`, output, 1: a frame is in progress.
- `done`, output, 1: one-cycle pulse after the checksum byte has been accepted.

## Operation
- **Frame format:** 23 bytes in this order:
  - `HEADER`;
  - data bytes D0..D20;
  - checksum C = D0 ^ D1 ^ ... ^ D20. The header is not included in C.
- **Cell packing:**
  - Cell index k = row*9 + col, k = 0..80.
  - Byte Dj holds cells 4j..4j+3: cell 4j in bits [1:0], 4j+1 in [3:2], 4j+2 in [5:4], 4j+3 in [7:6].
  - D20 holds cell 80 in bits [1:0]; bits [7:2] are 0.
- **Snapshot:** all 162 board bits are registered when `start` is accepted. Changes to `board_in` during a frame do not affect that frame.
- **States and transitions:**
  - IDLE: `start`=1 → HDR, with snapshot taken and data index cleared to 0.
  - HDR: handshake → DATA.
  - DATA: each handshake increments the 5-bit byte index j and XORs Dj into the checksum register. Handshake at j=20 → CSUM.
  - CSUM: handshake → DONE.
  - DONE: unconditionally → IDLE after one cycle.
- **Handshake:**
  - A transfer occurs on a rising edge where `tx_valid` and `tx_ready` are both 1.
  - While `tx_valid`=1 and no transfer occurs, `tx_data` holds stable.
  - `tx_valid` is never withdrawn before a transfer.
  - `tx_ready` is ignored while `tx_valid`=0.
- **Outputs by state:**
  - `tx_valid`=1 in HDR, DATA and CSUM only.
  - `busy`=1 in HDR, DATA and CSUM.
  - `done`=1 only in DONE.
- **`start` handling:** ignored in every state except IDLE. This includes DONE, so there is no back-to-back frame without one IDLE cycle.
- **Reset:** `reset_n`=0 at any time, including mid-frame, aborts the frame with no resume. All registers clear: state IDLE, index 0, checksum 0, snapshot all 0.
- **Reset values of outputs:** `tx_data`=8'h00, `tx_valid`=0, `busy`=0, `done`=0.
- **`tx_data` when `tx_valid`=0:** 8'h00.

## Timing
- **Start latency:** `start` high at edge N in IDLE gives `tx_valid`=1, `tx_data`=`HEADER` and `busy`=1 from edge N onward, i.e. visible in cycle N+1.
- **Throughput:** one byte per cycle while `tx_ready` is held at 1. With `tx_ready` constantly 1:
  - 23 consecutive valid cycles;
  - `done` high in the cycle after the checksum transfer;
  - IDLE in the cycle after that.
  - Total from `start` to a new `start` being acceptable: 25 cycles.
- **Stalls:** each cycle with `tx_ready`=0 stretches the frame by exactly one cycle with no byte lost or duplicated.
- **Data path timing:**
  - Dj is selected combinationally from the snapshot using the registered index. It must meet timing at the `clk_in` target with a 21:1 mux.
  - The checksum register updates on the same edge as the data transfer.
  - The value driven in CSUM is the final XOR.
- **Reset timing:** deasserting `reset_n` takes effect at the next edge. `start` is first sampled on the first rising edge after deassertion.

## Test plan
- **Empty board:**
  - Stimulus: all cells 00, `start` pulse, `tx_ready`=1.
  - Required: bytes A5, 21 × 00, 00; `done` pulses once 24 cycles after `start`; `busy` low afterwards.
- **Corner cells:**
  - Stimulus: [0][0]=01 and [8][8]=10, all other cells empty.
  - Required: D0=0x01, D1..D19=0x00, D20=0x02, C=0x03.
- **Packing order:**
  - Stimulus: cells 0..3 = b, w, b, w, rest empty.
  - Required: D0=0x99, C=0x99.
- **Backpressure:**
  - Stimulus: `tx_ready` toggles 1,0,0,1 repeating.
  - Required: `tx_data` is stable across every stalled cycle; the received stream is identical to the unstalled case; `done` still pulses exactly once.
- **Snapshot and ignored start:**
  - Stimulus: set [0][1]=01 and re-pulse `start` during DATA.
  - Required: frame content equals the board at the original `start`; no second frame begins.
- **Reset mid-frame:**
  - Stimulus: drive `reset_n`=0 at data byte D7.
  - Required: `tx_valid`, `busy`, `done` and `tx_data` go to 0 immediately. After release, a new `start` produces a complete frame beginning with A5 and a checksum computed from fresh state.
